// File: rtl/dr_sync_rx.sv
// dr_sync_rx: receiver for a dual-rail async link (two-phase TP or four-phase RZ FP), synchronised into clk,
// decoded to single-rail and presented on a valid/ready stream. DR_SYNC_RX_ERR_EN builds encoding-violation detection.
module dr_sync_rx #(
  parameter int WIDTH       = 32,
  parameter     ENC         = "TP",
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0][1:0] in,
  output logic                  ack_o,
  output logic [WIDTH-1:0]      dat,
  output logic                  vld,
  input  logic                  rdy,
  output logic                  err
);
  localparam bit IS_FP = (ENC == "FP");

  typedef enum logic {WAIT_DATA, WAIT_SPACER} state_t;

  logic [SYNC_STAGES-1:0][WIDTH-1:0][1:0] sync_q;
  logic [WIDTH-1:0][1:0] view_q, ref_q, ref_d, delta;
  logic [WIDTH-1:0]      dec, bit_ok, dat_q, dat_d;
  state_t                state_q, state_d;
  logic                  ack_q, ack_d, vld_q, vld_d;
  logic                  complete, spacer, viol, slot_free, cap;

  // Extra view register after the synchroniser: completion is judged one cycle after s settles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      view_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
      view_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // TP rails carry information as a change against ref; FP rails as a level.
  assign delta = IS_FP ? view_q : (view_q ^ ref_q);

  always_comb begin
    dec    = '0;
    bit_ok = '0;
    for (int i = 0; i < WIDTH; i++) begin
      dec[i] = delta[i][1];
`ifdef DR_SYNC_RX_ERR_EN
      bit_ok[i] = ^delta[i];
`else
      bit_ok[i] = |delta[i];
`endif
    end
  end

  assign complete  = &bit_ok;
  assign spacer    = (view_q == '0);
  assign slot_free = !vld_q || rdy;
  assign cap       = (state_q == WAIT_DATA) && complete && slot_free && !viol;

`ifdef DR_SYNC_RX_ERR_EN
  logic [WIDTH-1:0][1:0] prev_q;
  logic                  both, rise, err_q;

  always_comb begin
    both = 1'b0;
    for (int i = 0; i < WIDTH; i++) both = both | (&delta[i]);
  end
  assign rise = IS_FP && (state_q == WAIT_SPACER) && (|(view_q & ~prev_q));
  assign viol = both || rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= view_q;
      err_q  <= err_q | viol;
    end
  end
  assign err = err_q;
`else
  assign viol = 1'b0;
  assign err  = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_DATA;
      ack_q   <= 1'b0;
      ref_q   <= '0;
      dat_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      ref_q   <= ref_d;
      dat_q   <= dat_d;
      vld_q   <= vld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_DATA:   if (cap && IS_FP) state_d = WAIT_SPACER;
      WAIT_SPACER: if (spacer && !viol) state_d = WAIT_DATA;
      default:     state_d = WAIT_DATA;
    endcase
  end

  // Holding ack while the slot is full is what backpressures the transmitter.
  always_comb begin
    ack_d = ack_q;
    ref_d = ref_q;
    dat_d = dat_q;
    vld_d = vld_q && !rdy;
    if (cap) begin
      dat_d = dec;
      vld_d = 1'b1;
      if (IS_FP) begin
        ack_d = 1'b1;
      end else begin
        ack_d = !ack_q;
        ref_d = view_q;
      end
    end else if (state_q == WAIT_SPACER && spacer && !viol) begin
      ack_d = 1'b0;
    end
  end

  assign ack_o = ack_q;
  assign dat   = dat_q;
  assign vld   = vld_q;
endmodule

// File: tb/tb_dr_sync_rx.sv
// Bench for dr_sync_rx: TP and FP instances driven by transmitter models; a scoreboard of sent words
// is checked on every accepted output, plus latency, backpressure, skew and reset checks.
module tb_dr_sync_rx;
  localparam int W    = 8;
  localparam int SYNC = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0][1:0] tp_in, fp_in;
  logic              tp_rdy, fp_rdy, tp_ack, fp_ack, tp_vld, fp_vld, tp_err, fp_err;
  logic [W-1:0]      tp_dat, fp_dat;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [W-1:0] tp_q[$];
  logic [W-1:0] fp_q[$];
  bit         rnd_rdy = 1'b0;
  int         lat;

  dr_sync_rx #(.WIDTH(W), .ENC("TP"), .SYNC_STAGES(SYNC)) u_tp (
    .clk(clk), .rst(rst), .in(tp_in), .ack_o(tp_ack), .dat(tp_dat),
    .vld(tp_vld), .rdy(tp_rdy), .err(tp_err));

  dr_sync_rx #(.WIDTH(W), .ENC("FP"), .SYNC_STAGES(SYNC)) u_fp (
    .clk(clk), .rst(rst), .in(fp_in), .ack_o(fp_ack), .dat(fp_dat),
    .vld(fp_vld), .rdy(fp_rdy), .err(fp_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (rnd_rdy) begin
      tp_rdy = 1'($urandom);
      fp_rdy = 1'($urandom);
    end
  endtask

  // Scoreboard: every accepted word must be the oldest word sent and not yet accepted.
  always @(negedge clk) begin
    if (!rst && tp_vld && tp_rdy) begin
      if (tp_q.size() == 0) chk("tp_spurious", 1, 0);
      else chk("tp_dat", 32'(tp_dat), 32'(tp_q.pop_front()));
    end
    if (!rst && fp_vld && fp_rdy) begin
      if (fp_q.size() == 0) chk("fp_spurious", 1, 0);
      else chk("fp_dat", 32'(fp_dat), 32'(fp_q.pop_front()));
    end
  end

  // Transmitter: toggle one rail per bit (low half, gap cycles, high half), then await the ack toggle.
  task automatic tp_send(input logic [W-1:0] w, input int gap, output int n);
    logic a0;
    a0 = tp_ack;
    tp_q.push_back(w);
    for (int i = 0; i < W/2; i++) tp_in[i][w[i]] = ~tp_in[i][w[i]];
    for (int g = 0; g < gap; g++) begin
      tick();
      chk("tp_partial_ack", 32'(tp_ack), 32'(a0));
    end
    for (int i = W/2; i < W; i++) tp_in[i][w[i]] = ~tp_in[i][w[i]];
    n = 0;
    while (tp_ack == a0 && n < 200) begin tick(); n++; end
    chk("tp_ack_toggle", 32'(tp_ack), 32'(!a0));
  endtask

  task automatic fp_send(input logic [W-1:0] w, input int gap);
    int n;
    fp_q.push_back(w);
    for (int i = 0; i < W/2; i++) fp_in[i] = w[i] ? 2'b10 : 2'b01;
    for (int g = 0; g < gap; g++) begin
      tick();
      chk("fp_partial_ack", 32'(fp_ack), 0);
    end
    for (int i = W/2; i < W; i++) fp_in[i] = w[i] ? 2'b10 : 2'b01;
    n = 0;
    while (!fp_ack && n < 200) begin tick(); n++; end
    chk("fp_ack_rise", 32'(fp_ack), 1);
    fp_in = '0;
    n = 0;
    while (fp_ack && n < 200) begin tick(); n++; end
    chk("fp_ack_fall", 32'(fp_ack), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tp_in = '0;
    fp_in = '0;
    #2;
    chk("rst_tp_vld", 32'(tp_vld), 0);
    chk("rst_tp_ack", 32'(tp_ack), 0);
    chk("rst_tp_dat", 32'(tp_dat), 0);
    chk("rst_fp_vld", 32'(fp_vld), 0);
    chk("rst_fp_ack", 32'(fp_ack), 0);
    chk("rst_fp_err", 32'(fp_err), 0);
    tick(); tick();
    rst = 1'b0;
    tp_q.delete();
    fp_q.delete();
    tick();
  endtask

  initial begin
    logic [W-1:0] tp_seq [4];
    logic [W-1:0] a0;
    tp_in = '0; fp_in = '0; tp_rdy = 1'b1; fp_rdy = 1'b1;
    do_reset();

    // TP sequence; capture, vld and ack change land on edge SYNC+1 after the token (SYNC+2 edges counted).
    tp_seq = '{8'h00, 8'h01, 8'h01, 8'h02};
    for (int k = 0; k < 4; k++) begin
      tp_send(tp_seq[k], 0, lat);
      chk("tp_lat", 32'(lat), SYNC + 2);
      chk("tp_vld_on_ack", 32'(tp_vld), 1);
      chk("tp_dat_on_ack", 32'(tp_dat), 32'(tp_seq[k]));
    end
    tick();
    chk("tp_ack_end", 32'(tp_ack), 0);

    // FP words with spacers.
    fp_send(8'hA5, 0);
    fp_send(8'h3C, 0);
    tick(); tick();
    chk("fp_q_empty", 32'(fp_q.size()), 0);

    // Backpressure: second token held until one cycle of rdy.
    tick(); tick();
    tp_rdy = 1'b0;
    tp_send(8'h11, 0, lat);
    a0 = 8'(tp_ack);
    tp_q.push_back(8'h22);
    for (int i = 0; i < W; i++) tp_in[i][1'(8'h22 >> i)] = ~tp_in[i][1'(8'h22 >> i)];
    for (int c = 0; c < 8; c++) tick();
    chk("bp_ack_held", 32'(tp_ack), 32'(a0));
    chk("bp_vld", 32'(tp_vld), 1);
    chk("bp_dat", 32'(tp_dat), 32'h11);
    tp_rdy = 1'b1;
    tick();
    tp_rdy = 1'b0;
    chk("bp_dat2", 32'(tp_dat), 32'h22);
    chk("bp_vld2", 32'(tp_vld), 1);
    chk("bp_ack2", 32'(tp_ack), 32'(!a0[0]));
    tp_rdy = 1'b1;
    tick(); tick();
    chk("bp_q_empty", 32'(tp_q.size()), 0);

    // Skewed arrival: high half lags by 5 cycles; no ack change meanwhile, one capture of 0xFF.
    tp_send(8'hFF, 5, lat);
    chk("skew_lat", 32'(lat), SYNC + 2);
    tick(); tick();
    chk("skew_q_empty", 32'(tp_q.size()), 0);
    chk("skew_vld_done", 32'(tp_vld), 0);

`ifdef DR_SYNC_RX_ERR_EN
    for (int i = 0; i < W; i++) fp_in[i] = 2'b01;
    fp_in[2] = 2'b11;
    for (int c = 0; c < 6; c++) tick();
    chk("err_set", 32'(fp_err), 1);
    chk("err_novld", 32'(fp_vld), 0);
    chk("err_ack", 32'(fp_ack), 0);
    fp_in = '0;
    for (int c = 0; c < 4; c++) tick();
    chk("err_sticky", 32'(fp_err), 1);
    do_reset();
    chk("err_cleared", 32'(fp_err), 0);
`endif

    // Reset while holding a word; the next token decodes against all-zero reference rails.
    tp_rdy = 1'b0;
    tp_send(8'h5A, 0, lat);
    chk("hold_dat", 32'(tp_dat), 32'h5A);
    do_reset();
    tp_rdy = 1'b1;
    tp_send(8'hC3, 0, lat);
    chk("post_rst_lat", 32'(lat), SYNC + 2);
    chk("post_rst_dat", 32'(tp_dat), 32'hC3);
    tick(); tick();

    // Randomised traffic with random sink readiness and random skew.
    rnd_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      tp_send(8'($urandom), int'($urandom_range(0, 4)), lat);
      fp_send(8'($urandom), int'($urandom_range(0, 4)));
    end
    rnd_rdy = 1'b0;
    tp_rdy = 1'b1;
    fp_rdy = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    chk("rnd_tp_drained", 32'(tp_q.size()), 0);
    chk("rnd_fp_drained", 32'(fp_q.size()), 0);
    chk("tp_err_clear", 32'(tp_err), 0);
    chk("fp_err_clear", 32'(fp_err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dr_sync_rx.md
Name: dr_sync_rx

Overview:
- Clocked receiver terminating a dual-rail asynchronous output link such as the fib_tp `out`/`ack_i` pair.
- Synchronises the rails into the `clk` domain, detects codeword completion, decodes to single-rail and presents it on a valid/ready stream.
- Generates the link acknowledge back to the transmitter.
- Supports two-phase (TP) and four-phase return-to-zero (FP) dual-rail encodings.

Parameters:
- WIDTH, 32, data bits per codeword (rail pairs on `in`).
- ENC, "TP", link encoding: "TP" two-phase transition, "FP" four-phase RZ.
- SYNC_STAGES, 2, flip-flop synchroniser depth per rail, legal range 2..4.

Ports:
- clk  input  1  single clock.
- rst  input  1  reset: asynchronous, active-high.
- in  input  [WIDTH-1:0][1:0]  dual-rail data from the transmitter; rail[1] = logic 1, rail[0] = logic 0.
- ack_o  output  1  link acknowledge to the transmitter's ack_i.
- dat  output  WIDTH  decoded single-rail word.
- vld  output  1  dat holds an unconsumed word.
- rdy  input  1  sink accepts dat when vld&&rdy at a rising clk edge.
- err  output  1  sticky encoding-violation flag (see Optional Feature).

Behaviour:
- Reset values:
  - ack_o=0, vld=0, dat=0, err=0.
  - Synchroniser flops = 0.
  - TP reference rails ref = 0; FSM in WAIT_DATA.
- Reset mid-operation discards any held word and the in-flight token; no ack is generated for it.
- Synchroniser: every rail passes through SYNC_STAGES flops, giving synced view s.
  - Per-rail sync is safe because rails are monotonic within a phase and completion is only evaluated on the full word.
- Completion, TP: every bit has exactly one rail with s!=ref. Bit value = (s[i][1]!=ref[i][1]).
- Completion, FP: every bit has exactly one rail high. Bit value = s[i][1].
- Spacer, FP only: all s==0.
- Output slot is free when vld==0, or vld&&rdy in the current cycle (back-to-back acceptance).
- FSM states and transitions:
  - WAIT_DATA: if complete && slot free, then:
    - load dat with the decoded word and set vld=1;
    - TP: ref<=s and toggle ack_o, staying in WAIT_DATA;
    - FP: set ack_o=1 and go to WAIT_SPACER.
  - WAIT_DATA, complete but slot not free: hold; ack_o is unchanged, which stalls the transmitter (backpressure).
  - WAIT_SPACER (FP only): when spacer is seen, set ack_o=0 and go to WAIT_DATA.
- Capture, ack_o update and vld rise all happen on the same edge.
- Latency: a token stable at `in` before edge 0 gives vld=1 and the ack_o change after edge SYNC_STAGES+1 (edge 3 at default).
- vld clears on the vld&&rdy edge unless a new capture occurs on that same edge; then vld stays 1 with the new dat.
- Partial codewords, where some bits are not yet complete, are never captured.
- TP wrap: ref toggles indefinitely; there is no counter to overflow.

Optional Feature:
- Macro DR_SYNC_RX_ERR_EN.
- When defined, err is set and held until rst in either of these cases:
  - a bit has both rails changed (TP) or both high (FP) in s;
  - in FP WAIT_SPACER, a rail rises again before the spacer completes.
- A violating word is not captured and the FSM holds in its current state.
- When undefined: err is tied to 0, no detection logic is built, and completion uses only "at least one rail" per bit.

Test Plan:
- TP, WIDTH=8: drive 0x00 then 0x01, 0x01, 0x02 as rail toggles, rdy=1 → dat sequence 0x00,0x01,0x01,0x02. Each vld pulse occurs 3 cycles after its token; ack_o toggles 4 times and ends at 0.
- FP, WIDTH=8: word 0xA5, spacer, word 0x3C → dat 0xA5 then 0x3C. ack_o follows 0→1→0→1 in step with data, spacer, data.
- Backpressure: rdy=0, TP, two tokens 0x11, 0x22 → first captured with vld=1, dat=0x11. ack_o toggles once only; 0x22 is held off until rdy=1 for one cycle, then dat=0x22 on the following capture edge.
- Skewed arrival: bits 0..3 of token 0xFF change 5 cycles before bits 4..7 → no vld until all bits are complete, then a single capture of 0xFF.
- With DR_SYNC_RX_ERR_EN, FP: bit 2 both rails high → err=1 sticky, no capture, ack_o stays 0. Then assert rst mid-stream → err=0, vld=0, ack_o=0.
- Reset during TP hold with vld=1, dat=0x5A → all outputs return to 0. The next token is decoded against ref=0 rails.
